// File: rtl/trig_pkg.sv
// ---------------------------------------------------------------------------
// trig_pkg
//   Shared types and constants for the trigger conditioner.
//   - trig_state_t : press/release FSM states
//   - PRESS_CNT_W  : width of the accepted-press debug counter
//   - max3         : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package trig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    FIRE,
    HELD,
    DB_REL
  } trig_state_t;

  localparam int PRESS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trigger_conditioner_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Generic multi-flop synchroniser for a single asynchronous level input.
//   Reusable for any async control input, not only the trigger button.
// Parameters
//   STAGES : number of flops in the chain (>= 2)
// Ports
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset (clears every stage)
//   d   : asynchronous input level
//   q   : synchronised level, valid in the clk domain
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Bit 0 captures the raw input; each later stage takes the one before it.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// ---------------------------------------------------------------------------
// trigger_conditioner
//   Conditions the raw push-button feeding the CPU trigger port: synchronises
//   it, debounces press and release, emits exactly one HOLD_CYCLES-wide
//   trigger pulse per debounced press and counts accepted presses.
// Optional feature
//   TRIG_REPEAT_EN : when defined, a button held in HELD for REPEAT_CYCLES
//                    cycles fires an extra pulse (auto-repeat). When
//                    undefined, exactly one pulse per press.
// Parameters
//   SYNC_STAGES     : synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press/release (>= 1)
//   HOLD_CYCLES     : trigger pulse width in cycles (>= 1)
//   REPEAT_CYCLES   : held cycles before an auto-repeat pulse
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous, active-high reset
//   btn_in      : raw asynchronous button level, active-high
//   enable      : 0 = ignore the button and abort any pulse in progress
//   trigger     : registered conditioned trigger (high exactly in FIRE)
//   busy        : registered, high whenever the FSM is not IDLE
//   press_count : accepted presses including repeats, wraps 255 -> 0
// ---------------------------------------------------------------------------
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  input  logic                   enable,
  output logic                   trigger,
  output logic                   busy,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // One counter serves debounce, hold and repeat timing, so it is sized for
  // the largest of the three terminal counts.
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef TRIG_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic btn_s;

  trig_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   trigger_q, trigger_d;
  logic                   busy_q, busy_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Next-state logic. Outputs are derived from the next state so that the
  // registered trigger/busy line up exactly with the registered state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_count_d = press_count_q;

    if (!enable) begin
      // Disable wins over everything and aborts a pulse in progress.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end

        DB_PRESS: begin
          if (!btn_s) begin
            state_d = IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_d       = FIRE;
            cnt_d         = '0;
            press_count_d = press_count_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        FIRE: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        HELD: begin
          if (!btn_s) begin
            state_d = DB_REL;
            cnt_d   = '0;
          end
`ifdef TRIG_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            state_d       = FIRE;
            cnt_d         = '0;
            press_count_d = press_count_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end

        DB_REL: begin
          // A bounce back to 1 returns to HELD with a fresh count so the
          // repeat interval restarts from the bounce.
          if (btn_s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    trigger_d = (state_d == FIRE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_count_q <= '0;
      trigger_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
      trigger_q     <= trigger_d;
      busy_q        <= busy_d;
    end
  end

  assign trigger     = trigger_q;
  assign busy        = busy_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// ---------------------------------------------------------------------------
// tb_trigger_conditioner
//   Directed bench for trigger_conditioner with SYNC=2, DB=4, HOLD=3,
//   REPEAT=8. Stimulus pushes each expected pulse (rise edge, width, press
//   count at rise) into a queue; a monitor pops and compares on every
//   completed trigger pulse. Edge numbering: cycle holds the number of
//   rising edges seen so far, so a value driven after a falling edge is
//   first sampled by edge cycle+1.
// ---------------------------------------------------------------------------
module tb_trigger_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 3;
  localparam int REP  = 8;

  // Edge (counted from the first sampling edge) after which trigger rises.
  localparam int RISE_OFS = SYNC + DB;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       enable;
  logic       trigger;
  logic       busy;
  logic [7:0] press_count;

  typedef struct {
    int rise;
    int width;
    int count;
  } pulse_t;

  pulse_t exp_q[$];

  int cycle      = 0;
  int compared   = 0;
  int mismatched = 0;
  int start_edge;

  trigger_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .enable      (enable),
    .trigger     (trigger),
    .busy        (busy),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic level, input int n);
    btn_in = level;
    tick(n);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic expectPulse(input int rise, input int width, input int count);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    p.count = count;
    exp_q.push_back(p);
  endtask

  // Monitor: measures each trigger pulse and checks it against the queue.
  logic   trig_prev = 1'b0;
  int     rise_edge;
  int     rise_count;
  pulse_t got;

  always @(negedge clk) begin
    if (trigger === 1'b1 && trig_prev !== 1'b1) begin
      rise_edge  = cycle;
      rise_count = int'(press_count);
    end else if (trigger !== 1'b1 && trig_prev === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: got pulse rising at edge %0d, expected none", rise_edge);
      end else begin
        got = exp_q.pop_front();
        checkOutput("pulse_rise_edge", rise_edge, got.rise);
        checkOutput("pulse_width", cycle - rise_edge, got.width);
        checkOutput("pulse_press_count", rise_count, got.count);
      end
    end
    trig_prev = trigger;
  end

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    enable = 1'b1;
    tick(3);

    // Reset state
    checkOutput("reset_trigger", trigger, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_press_count", press_count, 0);
    rst = 1'b0;
    tick(2);

    // 1. Clean press, 30 cycles, then release and watch busy drop.
    start_edge = cycle + 1;
    expectPulse(start_edge + RISE_OFS, HOLD, 1);
    applyStimulus(1'b1, 30);
    // First 0-sampling edge is start+30; HELD->DB_REL at +32, IDLE at +36.
    applyStimulus(1'b0, 6);
    checkOutput("clean_busy_before_idle", busy, 1);
    tick(1);
    checkOutput("clean_busy_after_idle", busy, 0);
    tick(5);
    checkOutput("clean_press_count", press_count, 1);
    checkOutput("clean_trigger_low", trigger, 0);
    checkOutput("clean_pending", exp_q.size(), 0);

    // 2. Glitch shorter than the debounce window.
    doReset();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    checkOutput("glitch_press_count", press_count, 0);
    checkOutput("glitch_busy", busy, 0);
    checkOutput("glitch_pending", exp_q.size(), 0);

    // 3. Release bounce while HELD.
    doReset();
    start_edge = cycle + 1;
    expectPulse(start_edge + RISE_OFS, HOLD, 1);
    applyStimulus(1'b1, 14);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 2);
    end
    applyStimulus(1'b0, 15);
    checkOutput("bounce_press_count", press_count, 1);
    checkOutput("bounce_busy", busy, 0);
    checkOutput("bounce_pending", exp_q.size(), 0);

    // 4. Abort with enable=0 during the second FIRE cycle.
    doReset();
    start_edge = cycle + 1;
    expectPulse(start_edge + RISE_OFS, 2, 1);
    applyStimulus(1'b1, RISE_OFS + 1);
    tick(1);
    enable = 1'b0;
    tick(1);
    checkOutput("abort_trigger", trigger, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_press_count", press_count, 1);
    applyStimulus(1'b0, 3);
    enable = 1'b1;
    tick(10);
    checkOutput("abort_press_count_kept", press_count, 1);
    checkOutput("abort_pending", exp_q.size(), 0);

    // Reset asserted in the first FIRE cycle.
    doReset();
    start_edge = cycle + 1;
    expectPulse(start_edge + RISE_OFS, 1, 1);
    applyStimulus(1'b1, RISE_OFS + 1);
    rst = 1'b1;
    tick(1);
    checkOutput("midreset_trigger", trigger, 0);
    checkOutput("midreset_press_count", press_count, 0);
    btn_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(5);
    checkOutput("midreset_pending", exp_q.size(), 0);

    // 5. Counter wrap over 256 clean presses.
    doReset();
    for (int i = 0; i < 256; i++) begin
      start_edge = cycle + 1;
      expectPulse(start_edge + RISE_OFS, HOLD, (i + 1) % 256);
      applyStimulus(1'b1, 12);
      applyStimulus(1'b0, 10);
    end
    checkOutput("wrap_press_count", press_count, 0);
    checkOutput("wrap_pending", exp_q.size(), 0);

    // 6. Button held 40 cycles.
    doReset();
    start_edge = cycle + 1;
    expectPulse(start_edge + RISE_OFS, HOLD, 1);
`ifdef TRIG_REPEAT_EN
    for (int k = 1; k < 4; k++) begin
      expectPulse(start_edge + RISE_OFS + k * (REP + HOLD), HOLD, k + 1);
    end
`endif
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 20);
`ifdef TRIG_REPEAT_EN
    checkOutput("held_press_count", press_count, 4);
`else
    checkOutput("held_press_count", press_count, 1);
`endif
    checkOutput("held_busy", busy, 0);
    checkOutput("held_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
